// File: rtl/instr_sequencer_if.sv
// Instruction-memory fetch handshake between the sequencer (master) and instruction memory (slave).
interface instr_sequencer_if #(
  parameter int unsigned ADDR_W = 32
);
  localparam int unsigned INSTR_W = 32;

  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_rdata;

  modport master (output imem_req, imem_addr, input imem_ack, imem_rdata);
  modport slave  (input imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/instr_sequencer.sv
// Fetch/issue sequencer for the single-cycle MIPS datapath: fetches over req/ack,
// issues to the decoder, selects the next PC from jump/branch/zero, stops on the halt opcode.
module instr_sequencer #(
  parameter int unsigned       ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  instr_sequencer_if.master  imem,
  output logic [31:0]        instr,
  output logic [5:0]         opcode,
  output logic               instr_valid,
  input  logic               exec_done,
  input  logic               jump,
  input  logic               branch,
  input  logic               alu_zero,
  output logic [ADDR_W-1:0]  pc,
  output logic               halted,
  output logic [31:0]        retired
);

  localparam int unsigned OPC_W   = 6;
  localparam int unsigned IMM_W   = 16;
  localparam int unsigned TGT_W   = 26;
  localparam logic [OPC_W-1:0] HALT_OPC = 6'b111111;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    ISSUE = 2'd2,
    HALT  = 2'd3
  } state_t;

  state_t            state;
  logic              req_q;
  logic [ADDR_W-1:0] pc4_c;
  logic [ADDR_W-1:0] br_off_c;
  logic [ADDR_W-1:0] next_pc_c;

  assign imem.imem_req  = req_q;
  assign imem.imem_addr = pc;
  assign opcode         = instr[31:26];

  // Next-PC selection; jump wins over a taken branch.
  always_comb begin
    pc4_c     = pc + ADDR_W'(4);
    br_off_c  = {{(ADDR_W-IMM_W-2){instr[IMM_W-1]}}, instr[IMM_W-1:0], 2'b00};
    next_pc_c = pc4_c;
    if (jump) begin
      next_pc_c = {pc4_c[ADDR_W-1:TGT_W+2], instr[TGT_W-1:0], 2'b00};
    end else if (branch && alu_zero) begin
      next_pc_c = pc4_c + br_off_c;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= BOOT;
      pc          <= RESET_PC;
      instr       <= '0;
      instr_valid <= 1'b0;
      req_q       <= 1'b0;
      halted      <= 1'b0;
      retired     <= '0;
    end else begin
      case (state)
        BOOT: begin
          state <= FETCH;
          req_q <= 1'b1;
        end
        FETCH: begin
          if (imem.imem_ack) begin
            instr <= imem.imem_rdata;
            req_q <= 1'b0;
            // The halt word is captured but never issued or retired.
            if (imem.imem_rdata[31:26] == HALT_OPC) begin
              state  <= HALT;
              halted <= 1'b1;
            end else begin
              state       <= ISSUE;
              instr_valid <= 1'b1;
            end
          end
        end
        ISSUE: begin
          if (exec_done) begin
            pc          <= next_pc_c;
            retired     <= retired + 32'd1;
            instr_valid <= 1'b0;
            req_q       <= 1'b1;
            state       <= FETCH;
          end
        end
        HALT: begin
          state <= HALT;
        end
        default: begin
          state <= BOOT;
        end
      endcase
    end
  end

endmodule
